// File: rtl/sb_pkg.sv
// Shared types for the store buffer between the memory stage and DM.
// Entry layout and the default FIFO depth live here.
package sb_pkg;

  localparam int SB_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic        isbyte;
  } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// In-order ring of pending stores with a per-entry word-address compare.
// hit_vec bits are masked so only occupied slots can report a match.
module sb_fifo
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  sb_entry_t        wdata,
  input  logic [29:0]      cmp_word,
  output sb_entry_t        head,
  output logic [PTR_W:0]   count,
  output logic [DEPTH-1:0] hit_vec
);

  sb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign head = mem[rd_ptr];

  // a slot is live when its distance from the head is below count
  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    logic [PTR_W-1:0] off;
    assign off = PTR_W'(g) - rd_ptr;
    assign hit_vec[g] = ({1'b0, off} < count) &&
                        (mem[g].addr[31:2] == cmp_word);
  end

endmodule

// File: rtl/store_buffer.sv
// Write buffer in front of DM: queues stores, drains them when no load
// owns the port, and stalls loads that hit a pending store word.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           st_valid,
  output logic           st_ready,
  input  logic [31:0]    st_pc,
  input  logic [31:0]    st_addr,
  input  logic [31:0]    st_data,
  input  logic           st_byte,
  input  logic           ld_valid,
  input  logic [31:0]    ld_addr,
  output logic           ld_stall,
  output logic [31:0]    dm_pc,
  output logic [31:0]    dm_addr,
  output logic [31:0]    dm_data,
  output logic           dm_memwrite,
  output logic           dm_isbyte,
  output logic [PTR_W:0] count,
  output logic           empty
);

  sb_entry_t        head;
  sb_entry_t        wdata;
  logic [DEPTH-1:0] hit_vec;
  logic             push;
  logic             pop;
  logic             hit;
  logic             ld_own;

  assign wdata = '{pc: st_pc, addr: st_addr,
                   data: st_data, isbyte: st_byte};

  assign st_ready = count != (PTR_W+1)'(DEPTH);
  assign empty    = count == '0;
  assign push     = st_valid && st_ready;
  assign hit      = ld_valid && |hit_vec;
  assign ld_stall = hit;
  assign ld_own   = ld_valid && !hit;
  // a stalled load yields the port so its blocking store can drain
  assign pop      = !ld_own && !empty && !reset;

  sb_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .wdata    (wdata),
    .cmp_word (ld_addr[31:2]),
    .head     (head),
    .count    (count),
    .hit_vec  (hit_vec)
  );

  always_comb begin
    dm_pc       = head.pc;
    dm_data     = head.data;
    dm_addr     = ld_own ? ld_addr : head.addr;
    dm_isbyte   = ld_own ? 1'b0 : head.isbyte;
    dm_memwrite = pop;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: DM stand-in, queue reference model, table and
// directed sequences, then a randomized run.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_pc;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_byte;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_stall;
  logic [31:0] dm_pc;
  logic [31:0] dm_addr;
  logic [31:0] dm_data;
  logic        dm_memwrite;
  logic        dm_isbyte;
  logic [2:0]  count;
  logic        empty;

  store_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_pc       (st_pc),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_byte     (st_byte),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_stall    (ld_stall),
    .dm_pc       (dm_pc),
    .dm_addr     (dm_addr),
    .dm_data     (dm_data),
    .dm_memwrite (dm_memwrite),
    .dm_isbyte   (dm_isbyte),
    .count       (count),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic        isbyte;
  } st_t;

  typedef struct {
    logic        sv;
    logic [31:0] sa;
    logic [31:0] sd;
    logic        lv;
    logic [31:0] la;
    logic [2:0]  ec;
    logic        er;
    logic        emw;
    logic [31:0] ea;
  } vec_t;

  st_t         q[$];
  logic [31:0] dm      [256];
  logic [31:0] ref_mem [256];
  logic [31:0] pc_ctr;
  int          checks = 0;
  int          errors = 0;

  logic [2:0]  s_count;
  logic        s_ready, s_mw, s_stall, s_empty;
  logic [31:0] s_addr, s_rd;

  // DM stand-in: combinational read, synchronous word/byte write
  always @(posedge clk) begin
    if (dm_memwrite) begin
      if (dm_isbyte)
        dm[dm_addr[9:2]][8*dm_addr[1:0] +: 8] <= dm_data[8*dm_addr[1:0] +: 8];
      else
        dm[dm_addr[9:2]] <= dm_data;
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic ref_write(input st_t e);
    int lane;
    lane = int'(e.addr[1:0]);
    if (e.isbyte)
      ref_mem[e.addr[9:2]][8*lane +: 8] = e.data[8*lane +: 8];
    else
      ref_mem[e.addr[9:2]] = e.data;
  endtask

  task automatic step(input logic sv, input logic [31:0] sa,
                      input logic [31:0] sd, input logic sb,
                      input logic lv, input logic [31:0] la,
                      input logic rs);
    logic hit, own, mw, acc;
    st_t  e;
    st_valid = sv; st_pc = pc_ctr; st_addr = sa;
    st_data = sd; st_byte = sb;
    ld_valid = lv; ld_addr = la; reset = rs;
    @(negedge clk);
    hit = 1'b0;
    foreach (q[i]) if (lv && q[i].addr[31:2] == la[31:2]) hit = 1'b1;
    own = lv && !hit;
    mw  = !rs && !own && q.size() != 0;
    s_count = count; s_ready = st_ready; s_mw = dm_memwrite;
    s_stall = ld_stall; s_empty = empty; s_addr = dm_addr;
    s_rd = dm[la[9:2]];
    chk("ld_stall", ld_stall, hit);
    chk("dm_memwrite", dm_memwrite, mw);
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("st_ready", st_ready, q.size() != DEPTH);
    if (mw) begin
      chk("wr_pc", dm_pc, q[0].pc);
      chk("wr_addr", dm_addr, q[0].addr);
      chk("wr_data", dm_data, q[0].data);
      chk("wr_isbyte", dm_isbyte, q[0].isbyte);
    end
    if (own) begin
      chk("ld_addr", dm_addr, la);
      chk("ld_isbyte", dm_isbyte, 1'b0);
      chk("ld_data", dm[la[9:2]], ref_mem[la[9:2]]);
    end
    acc = sv && q.size() != DEPTH;
    e = '{pc: pc_ctr, addr: sa, data: sd, isbyte: sb};
    @(posedge clk);
    if (rs) q.delete();
    else begin
      if (mw) begin
        ref_write(q[0]);
        void'(q.pop_front());
      end
      if (acc) q.push_back(e);
    end
    pc_ctr += 4;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic b);
    step(1'b1, a, d, b, 1'b0, 32'h0, 1'b0);
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b1, 32'h100, 32'hA0, 1'b1, 32'h1000, 3'd0, 1'b1, 1'b0, 32'h1000};
    tbl[1]  = '{1'b1, 32'h104, 32'hA1, 1'b1, 32'h1000, 3'd1, 1'b1, 1'b0, 32'h1000};
    tbl[2]  = '{1'b1, 32'h108, 32'hA2, 1'b1, 32'h1000, 3'd2, 1'b1, 1'b0, 32'h1000};
    tbl[3]  = '{1'b1, 32'h10C, 32'hA3, 1'b1, 32'h1000, 3'd3, 1'b1, 1'b0, 32'h1000};
    tbl[4]  = '{1'b1, 32'h110, 32'hA4, 1'b1, 32'h1000, 3'd4, 1'b0, 1'b0, 32'h1000};
    tbl[5]  = '{1'b1, 32'h110, 32'hA4, 1'b0, 32'h0,    3'd4, 1'b0, 1'b1, 32'h100};
    tbl[6]  = '{1'b1, 32'h110, 32'hA4, 1'b0, 32'h0,    3'd3, 1'b1, 1'b1, 32'h104};
    tbl[7]  = '{1'b0, 32'h0,   32'h0,  1'b0, 32'h0,    3'd3, 1'b1, 1'b1, 32'h108};
    tbl[8]  = '{1'b0, 32'h0,   32'h0,  1'b0, 32'h0,    3'd2, 1'b1, 1'b1, 32'h10C};
    tbl[9]  = '{1'b0, 32'h0,   32'h0,  1'b0, 32'h0,    3'd1, 1'b1, 1'b1, 32'h110};
    tbl[10] = '{1'b0, 32'h0,   32'h0,  1'b0, 32'h0,    3'd0, 1'b1, 1'b0, 32'h0};

    foreach (dm[i]) begin
      dm[i] = '0;
      ref_mem[i] = '0;
    end
    pc_ctr = 32'h400;
    reset = 1'b1; st_valid = 1'b0; st_pc = '0; st_addr = '0;
    st_data = '0; st_byte = 1'b0; ld_valid = 1'b0; ld_addr = '0;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    idle();
    chk("reset_count", s_count, 3'd0);
    chk("reset_empty", s_empty, 1'b1);
    chk("reset_ready", s_ready, 1'b1);
    chk("reset_stall", s_stall, 1'b0);
    chk("reset_mw", s_mw, 1'b0);

    // single drain
    st(32'h10, 32'hDEADBEEF, 1'b0);
    idle();
    chk("drain_mw", s_mw, 1'b1);
    chk("drain_addr", s_addr, 32'h10);
    idle();
    chk("drain_empty", s_empty, 1'b1);
    chk("drain_dm", dm[4], 32'hDEADBEEF);

    // fill while loads hold the port
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].sv, tbl[i].sa, tbl[i].sd, 1'b0, tbl[i].lv, tbl[i].la, 1'b0);
      chk($sformatf("fill%0d_count", i), s_count, tbl[i].ec);
      chk($sformatf("fill%0d_ready", i), s_ready, tbl[i].er);
      chk($sformatf("fill%0d_mw", i), s_mw, tbl[i].emw);
      if (tbl[i].emw || tbl[i].lv)
        chk($sformatf("fill%0d_addr", i), s_addr, tbl[i].ea);
    end
    chk("fill_dm_last", dm[32'h110 >> 2], 32'hA4);

    // load hit on pending word
    st(32'h20, 32'h11223344, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h22, 1'b0);
    chk("hit_stall", s_stall, 1'b1);
    chk("hit_mw", s_mw, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h22, 1'b0);
    chk("hit_release", s_stall, 1'b0);
    chk("hit_byte", {24'h0, s_rd[23:16]}, 32'h22);

    // byte stores to one word drain in order
    st(32'h40, 32'h000000AA, 1'b1);
    st(32'h41, 32'h0000BB00, 1'b1);
    idle();
    idle();
    chk("byte_word", dm[32'h40 >> 2], 32'h0000BBAA);

    // reset with three entries pending
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h200 + 32'(4*i), 32'h55 + 32'(i), 1'b0, 1'b1, 32'h1000, 1'b0);
    chk("rst_pending", s_count, 3'd2);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("rst_mw_during", s_mw, 1'b0);
    idle();
    chk("rst_count", s_count, 3'd0);
    chk("rst_mw_after", s_mw, 1'b0);
    for (int i = 0; i < 3; i++)
      chk($sformatf("rst_dm%0d", i), dm[(32'h200 >> 2) + i], 32'h0);

    // pointer wrap with push and drain every cycle
    st(32'h80, 32'h1000, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      st(32'h80 + 32'(4*i), 32'h1000 + 32'(i), 1'b0);
      chk($sformatf("wrap%0d_count", i), s_count, 3'd1);
    end
    idle();
    idle();
    for (int i = 0; i <= 10; i++)
      chk($sformatf("wrap_dm%0d", i), dm[(32'h80 >> 2) + i], 32'h1000 + 32'(i));

    // randomized traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      logic        sv, sb, lv;
      logic [1:0]  lane;
      logic [31:0] sa, sd, la;
      sv   = 1'($urandom_range(0, 1));
      sb   = 1'($urandom_range(0, 1));
      lv   = ($urandom_range(0, 2) == 0);
      lane = sb ? 2'($urandom_range(0, 3)) : 2'd0;
      sa   = 32'h300 + 32'($urandom_range(0, 15) << 2) + 32'(lane);
      sd   = sb ? (32'($urandom_range(0, 255)) << (8 * lane)) : $urandom;
      la   = 32'h300 + 32'($urandom_range(0, 63));
      step(sv, sa, sd, sb, lv, la, 1'b0);
    end
    for (int n = 0; n < 8 && q.size() != 0; n++) idle();
    chk("rand_drained", q.size(), 0);
    begin
      int bad;
      bad = 0;
      foreach (dm[i]) if (dm[i] !== ref_mem[i]) bad++;
      chk("mem_final", bad, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
